trace_logger: RTL and testbench
===============================

TRACE_LOGGER -- requirements
Module: trace_logger

Interface
REQ-001 Parameters SHALL be: TRB_WIDTH, default 32, trace word width; TRB_DEPTH, default 64, ring-buffer entries (power of two); TRB_ADDR_WIDTH, default $clog2(TRB_DEPTH), pointer width.
REQ-002 Ports SHALL be:
- CLK_I, in, 1: the single clock.
- RST_I, in, 1: reset, synchronous and active-high.
- MODE_I, in, 1: 1 = stream mode, 0 = trigger mode.
- TRG_EVENT_I, in, 1: trigger pulse.
- TRG_DELAY_I, in, TRB_ADDR_WIDTH: post-trigger beat count.
- DATA_I, in, TRB_WIDTH: trace data.
- VALID_I, in, 1: trace data valid.
- READY_O, out, 1: logger accepts DATA_I.
- RW_TURN_I, in, 1: controller turn; 0 = logger side may act.
- WRITE_ALLOW_I, in, 1: controller permits a logger write.
- READ_ALLOW_I, in, 1: controller has forwarded the entry at READ_PTR_O.
- READ_PTR_O, out, TRB_ADDR_WIDTH: oldest unread slot.
- WRITE_PTR_O, out, TRB_ADDR_WIDTH: next slot to write.
- WRITE_O, out, 1: write strobe to controller.
- DATA_O, out, TRB_WIDTH: write data to controller.
- FULL_O, out, 1: buffer full.
- EMPTY_O, out, 1: buffer empty.
- DONE_O, out, 1: trigger capture complete.
- OVERFLOW_O, out, 1: sticky; stream data was refused while full.

Function
REQ-003 Pointers SHALL be registered, increment by 1, and wrap from TRB_DEPTH-1 to 0.
REQ-004 EMPTY_O SHALL be (READ_PTR_O == WRITE_PTR_O); FULL_O SHALL be (WRITE_PTR_O+1 mod TRB_DEPTH == READ_PTR_O); usable capacity is TRB_DEPTH-1.
REQ-005 The FSM SHALL have states STREAM, ARMED, POST, DONE; the state after reset SHALL be STREAM if MODE_I=1, else ARMED.
REQ-006 READY_O SHALL be !RW_TURN_I && WRITE_ALLOW_I && (state==STREAM ? !FULL_O : state!=DONE), combinationally.
REQ-007 Accept = VALID_I && READY_O; WRITE_O SHALL equal accept and DATA_O SHALL equal DATA_I in the same cycle (zero latency); WRITE_PTR_O SHALL increment at that clock edge.
REQ-008 In STREAM and DONE, READ_PTR_O SHALL increment at the edge where !RW_TURN_I && READ_ALLOW_I && !EMPTY_O.
REQ-009 In ARMED and POST, an accept while FULL_O SHALL also increment READ_PTR_O (overwrite oldest); READ_ALLOW_I SHALL be ignored.
REQ-010 STREAM, simultaneous accept and read: both pointers SHALL advance; FULL_O/EMPTY_O reflect the new pointers next cycle.
REQ-011 ARMED: TRG_EVENT_I=1 SHALL load a counter with TRG_DELAY_I and go to POST, or go directly to DONE if TRG_DELAY_I==0; a beat accepted in the trigger cycle counts as pre-trigger.
REQ-012 POST: each accept SHALL decrement the counter; the accept at counter==1 SHALL move the FSM to DONE; TRG_EVENT_I SHALL be ignored.
REQ-013 DONE: DONE_O=1 and READY_O=0; the FSM SHALL stay in DONE until reset or a MODE_I change.
REQ-014 OVERFLOW_O SHALL set when state==STREAM && VALID_I && !RW_TURN_I && WRITE_ALLOW_I && FULL_O, and SHALL hold until reset.
REQ-015 A MODE_I change SHALL, at the next edge, clear pointers, the counter and OVERFLOW_O, and enter the reset state for the new MODE_I.

Reset
REQ-016 With RST_I=1 at an edge: pointers=0, counter=0, OVERFLOW_O=0, FSM per REQ-005; hence EMPTY_O=1, FULL_O=0, DONE_O=0.
REQ-017 Reset asserted mid-capture SHALL abort the capture; no WRITE_O SHALL occur during any cycle with RST_I=1.

Verification (TRB_DEPTH=8)
REQ-018 Stream fill: MODE_I=1, RW_TURN_I=0, WRITE_ALLOW_I=1, VALID_I=1 for 9 cycles, no reads -> 7 WRITE_O pulses, WRITE_PTR_O=7, FULL_O=1, READY_O=0, OVERFLOW_O=1.
REQ-019 Stream drain/wrap: after REQ-018, READ_ALLOW_I=1 for 7 cycles -> READ_PTR_O=7, EMPTY_O=1; one more write -> WRITE_PTR_O=0.
REQ-020 Turn gating: RW_TURN_I=1 with VALID_I=1 and both allows=1 -> READY_O=0, WRITE_O=0, pointers unchanged.
REQ-021 Trigger capture: MODE_I=0, 10 beats (0..9) then TRG_EVENT_I with TRG_DELAY_I=3 and 3 more beats -> overwrite keeps READ_PTR_O one slot ahead of WRITE_PTR_O, DONE_O=1, WRITE_PTR_O=13 mod 8=5, READY_O=0.
REQ-022 Zero delay: TRG_EVENT_I with TRG_DELAY_I=0 -> DONE_O=1 next cycle; no further writes.
REQ-023 Reset mid-POST: RST_I=1 for one cycle -> all outputs at REQ-016 values, FSM=ARMED.

Source files
------------

// File: rtl/trace_logger.sv
// trace_logger: ring-buffer trace capture front end.
// The logger owns the read/write pointers of a TRB_DEPTH-entry ring that lives
// in an external controller. Writes are zero-latency strobes (WRITE_O/DATA_O).
// Stream mode fills until full and flags refused data as overflow; trigger mode
// keeps overwriting the oldest entry until a trigger plus a programmable number
// of post-trigger beats have been captured, then freezes the buffer for readout.
module trace_logger #(
  parameter int TRB_WIDTH      = 32,
  parameter int TRB_DEPTH      = 64,
  parameter int TRB_ADDR_WIDTH = $clog2(TRB_DEPTH)
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      MODE_I,
  input  logic                      TRG_EVENT_I,
  input  logic [TRB_ADDR_WIDTH-1:0] TRG_DELAY_I,
  input  logic [TRB_WIDTH-1:0]      DATA_I,
  input  logic                      VALID_I,
  output logic                      READY_O,
  input  logic                      RW_TURN_I,
  input  logic                      WRITE_ALLOW_I,
  input  logic                      READ_ALLOW_I,
  output logic [TRB_ADDR_WIDTH-1:0] READ_PTR_O,
  output logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_O,
  output logic                      WRITE_O,
  output logic [TRB_WIDTH-1:0]      DATA_O,
  output logic                      FULL_O,
  output logic                      EMPTY_O,
  output logic                      DONE_O,
  output logic                      OVERFLOW_O
);

  localparam logic [TRB_ADDR_WIDTH-1:0] PTR_ONE = TRB_ADDR_WIDTH'(1);
  localparam logic [TRB_ADDR_WIDTH-1:0] PTR_ZERO = '0;

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [TRB_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [TRB_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [TRB_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      mode_q;

  logic                      mode_chg;
  logic                      full, empty;
  logic                      side_ok;
  logic                      ready;
  logic                      accept;
  logic                      rd_ok;
  logic [TRB_ADDR_WIDTH-1:0] wr_ptr_inc, rd_ptr_inc;

  // Pointer arithmetic: the ring is a power of two, so the natural
  // TRB_ADDR_WIDTH-bit overflow implements the wrap to 0.
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

  // One slot is sacrificed so that full and empty stay distinguishable.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (wr_ptr_inc == rd_ptr_q);

  // A mode flip is treated like a soft reset into the new mode's start state.
  assign mode_chg = (MODE_I != mode_q);

  // The logger side may only touch the ring on its turn with the controller's
  // blessing. Reset also blocks it so no stray write escapes during RST_I.
  assign side_ok = !RW_TURN_I && WRITE_ALLOW_I && !RST_I;

  // Readout is controller-driven and only meaningful when something is stored.
  assign rd_ok = !RW_TURN_I && READ_ALLOW_I && !empty;

  // Ready: stream mode stalls when full; trigger mode overwrites until done.
  always_comb begin
    ready = 1'b0;
    if (side_ok) begin
      unique case (state_q)
        ST_STREAM: ready = !full;
        ST_DONE:   ready = 1'b0;
        default:   ready = 1'b1;
      endcase
    end
  end

  assign accept = VALID_I && ready;

  // Next-state, pointer, post-trigger counter and overflow logic.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (accept) wr_ptr_d = wr_ptr_inc;

    unique case (state_q)
      ST_STREAM: begin
        // Reads and writes may both advance in the same cycle.
        if (rd_ok) rd_ptr_d = rd_ptr_inc;
        // Refused stream data is recorded; it stays set until reset/mode change.
        if (VALID_I && side_ok && full) ovf_d = 1'b1;
      end

      ST_ARMED: begin
        // Pre-trigger history: drop the oldest entry to make room.
        if (accept && full) rd_ptr_d = rd_ptr_inc;
        // A beat accepted alongside the trigger is still pre-trigger history.
        if (TRG_EVENT_I) begin
          if (TRG_DELAY_I == PTR_ZERO) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = TRG_DELAY_I;
            state_d = ST_POST;
          end
        end
      end

      ST_POST: begin
        if (accept) begin
          if (full) rd_ptr_d = rd_ptr_inc;
          cnt_d = cnt_q - PTR_ONE;
          if (cnt_q == PTR_ONE) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Capture is frozen; the controller drains it at its own pace.
        if (rd_ok) rd_ptr_d = rd_ptr_inc;
      end

      default: state_d = ST_STREAM;
    endcase
  end

  // State register; reset and mode changes both restart from a clean ring.
  always_ff @(posedge CLK_I) begin
    if (RST_I || mode_chg) begin
      state_q  <= MODE_I ? ST_STREAM : ST_ARMED;
      mode_q   <= MODE_I;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign READY_O     = ready;
  assign WRITE_O     = accept;
  assign DATA_O      = DATA_I;
  assign READ_PTR_O  = rd_ptr_q;
  assign WRITE_PTR_O = wr_ptr_q;
  assign FULL_O      = full;
  assign EMPTY_O     = empty;
  assign DONE_O      = (state_q == ST_DONE);
  assign OVERFLOW_O  = ovf_q;

endmodule

// File: tb/tb_trace_logger.sv
// tb_trace_logger: directed scenarios plus randomized traffic against an
// occupancy-based reference model of the trace logger (depth 8).
module tb_trace_logger;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, mode, trg, valid, turn, wallow, rallow;
  logic [AW-1:0] delay;
  logic [W-1:0]  data;
  logic          ready_o, write_o, full_o, empty_o, done_o, ovf_o;
  logic [AW-1:0] rptr_o, wptr_o;
  logic [W-1:0]  data_o;

  int checks = 0;
  int errors = 0;
  int wr_pulses;

  // Reference model: ring counts plus capture progress flags.
  int m_wr, m_rd, m_remain;
  bit m_ovf, m_mode, m_trig, m_done;

  always #5 clk = ~clk;

  trace_logger #(.TRB_WIDTH(W), .TRB_DEPTH(D), .TRB_ADDR_WIDTH(AW)) dut (
    .CLK_I(clk), .RST_I(rst), .MODE_I(mode), .TRG_EVENT_I(trg),
    .TRG_DELAY_I(delay), .DATA_I(data), .VALID_I(valid), .READY_O(ready_o),
    .RW_TURN_I(turn), .WRITE_ALLOW_I(wallow), .READ_ALLOW_I(rallow),
    .READ_PTR_O(rptr_o), .WRITE_PTR_O(wptr_o), .WRITE_O(write_o),
    .DATA_O(data_o), .FULL_O(full_o), .EMPTY_O(empty_o), .DONE_O(done_o),
    .OVERFLOW_O(ovf_o)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_wr = 0; m_rd = 0; m_remain = 0;
    m_ovf = 0; m_trig = 0; m_done = 0;
    m_mode = mode;
  endtask

  // One clock: compare at the falling edge, then advance the model at the
  // rising edge. Inputs must be stable from the call until it returns.
  task automatic cycle();
    int occ;
    bit full, empty, gate, rdy, acc, was_done;
    @(negedge clk);
    occ   = (m_wr - m_rd + D) % D;
    full  = (occ == D - 1);
    empty = (occ == 0);
    gate  = !rst && !turn && wallow;
    rdy   = gate && (m_mode ? !full : !m_done);
    acc   = valid && rdy;
    chk("ready", ready_o, rdy);
    chk("write", write_o, acc);
    if (acc) chk("data", data_o, data);
    chk("full", full_o, full);
    chk("empty", empty_o, empty);
    chk("done", done_o, m_done);
    chk("ovf", ovf_o, m_ovf);
    chk("rptr", rptr_o, m_rd);
    chk("wptr", wptr_o, m_wr);
    if (write_o) wr_pulses++;
    @(posedge clk);
    was_done = m_done;
    if (rst || (mode != m_mode)) begin
      model_clear();
    end else if (m_mode) begin
      if (acc) m_wr = (m_wr + 1) % D;
      if (!turn && rallow && !empty) m_rd = (m_rd + 1) % D;
      if (valid && gate && full) m_ovf = 1;
    end else begin
      if (acc) begin
        m_wr = (m_wr + 1) % D;
        if (full) m_rd = (m_rd + 1) % D;
      end
      if (was_done) begin
        if (!turn && rallow && !empty) m_rd = (m_rd + 1) % D;
      end else if (!m_trig) begin
        if (trg) begin
          if (delay == 0) m_done = 1;
          else begin m_trig = 1; m_remain = int'(delay); end
        end
      end else if (acc) begin
        m_remain--;
        if (m_remain == 0) m_done = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; trg = 0; valid = 0; turn = 0; wallow = 1; rallow = 0;
    delay = '0; data = '0;
  endtask

  task automatic do_reset(input bit md);
    idle_inputs();
    mode = md; rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    mode = 1; rst = 1;
    // Power-up state is unknown to the model; take the first edge unchecked.
    @(posedge clk); #1;
    model_clear();
    rst = 0;

    // Reset values.
    do_reset(1);
    #1;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_ptrs", {rptr_o, wptr_o}, 0);

    // Stream fill: 9 offered beats, 7 accepted, then overflow.
    wr_pulses = 0;
    valid = 1;
    for (int i = 0; i < 9; i++) begin data = 32'hA000_0000 + i; cycle(); end
    valid = 0; #1;
    chk("fill_pulses", wr_pulses, 7);
    chk("fill_wptr", wptr_o, 7);
    chk("fill_full", full_o, 1);
    chk("fill_ready", ready_o, 0);
    chk("fill_ovf", ovf_o, 1);

    // Drain and wrap.
    rallow = 1;
    for (int i = 0; i < 7; i++) cycle();
    rallow = 0; #1;
    chk("drain_rptr", rptr_o, 7);
    chk("drain_empty", empty_o, 1);
    valid = 1; data = 32'h1234_5678;
    cycle();
    valid = 0; #1;
    chk("wrap_wptr", wptr_o, 0);

    // Turn gating.
    turn = 1; valid = 1; rallow = 1; wallow = 1; #1;
    chk("turn_ready", ready_o, 0);
    chk("turn_write", write_o, 0);
    cycle();
    chk("turn_rptr", rptr_o, 7);
    chk("turn_wptr", wptr_o, 0);
    idle_inputs();

    // Trigger capture: mode change into ARMED, 10 beats, trigger, 3 beats.
    mode = 0;
    cycle();
    valid = 1;
    for (int i = 0; i < 10; i++) begin data = i; cycle(); end
    valid = 0; trg = 1; delay = 3;
    cycle();
    trg = 0; valid = 1;
    for (int i = 10; i < 13; i++) begin data = i; cycle(); end
    #1;
    chk("trg_done", done_o, 1);
    chk("trg_wptr", wptr_o, 5);
    chk("trg_rptr", rptr_o, 6);
    chk("trg_ready", ready_o, 0);
    valid = 0;

    // Zero-delay trigger.
    do_reset(0);
    valid = 1;
    for (int i = 0; i < 2; i++) begin data = 32'hB0 + i; cycle(); end
    valid = 0; trg = 1; delay = 0;
    cycle();
    trg = 0; #1;
    chk("z_done", done_o, 1);
    valid = 1;
    for (int i = 0; i < 3; i++) cycle();
    valid = 0; #1;
    chk("z_wptr", wptr_o, 2);

    // Reset in the middle of a post-trigger capture.
    do_reset(0);
    trg = 1; delay = 5; valid = 1; data = 32'hC0;
    cycle();
    trg = 0; data = 32'hC1;
    cycle();
    rst = 1; #1;
    chk("rst_nowrite", write_o, 0);
    cycle();
    rst = 0; valid = 0; #1;
    chk("mp_empty", empty_o, 1);
    chk("mp_full", full_o, 0);
    chk("mp_done", done_o, 0);
    chk("mp_ovf", ovf_o, 0);
    chk("mp_ptrs", {rptr_o, wptr_o}, 0);
    // ARMED overwrites where STREAM would stall: 9 beats leave rptr at 2.
    valid = 1;
    for (int i = 0; i < 9; i++) begin data = i; cycle(); end
    valid = 0; #1;
    chk("mp_armed_rptr", rptr_o, 2);

    // Randomized traffic with occasional resets and mode flips.
    idle_inputs();
    for (int n = 0; n < 4000; n++) begin
      rst    = ($urandom_range(99) == 0);
      if ($urandom_range(149) == 0) mode = ~mode;
      turn   = ($urandom_range(3) == 0);
      wallow = ($urandom_range(4) != 0);
      rallow = ($urandom_range(2) == 0);
      valid  = ($urandom_range(2) != 0);
      trg    = ($urandom_range(15) == 0);
      delay  = AW'($urandom_range(D - 1));
      data   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
